// File: rtl/lfsr_arb.sv
// lfsr_arb: round-robin scheduler sharing one 8-bit maximal-length LFSR among NREQ requesters.
// Optional build macro LFSR_ARB_FREERUN_EN: LFSR steps on every non-reset, non-seed cycle.
module lfsr_arb #(
    parameter int unsigned NREQ      = 4,
    parameter logic [7:0]  SEED_INIT = 8'h01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            seed_we,
    input  logic [7:0]      seed,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [7:0]      rnd_data,
    output logic            period_wrap
);

    localparam int unsigned     PW       = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam int unsigned     IW       = PW + 1;
    localparam logic [IW-1:0]   NREQ_W   = IW'(NREQ);
    localparam logic [PW-1:0]   LAST_W   = PW'(NREQ - 1);
    localparam logic [NREQ-1:0] GNT_ONE  = NREQ'(1);
    localparam logic [7:0]      CNT_LAST = 8'd254;

    if ((NREQ < 2) || (NREQ > 8)) begin : g_bad_nreq
        $error("lfsr_arb: NREQ must lie within 2..8");
    end
    if (SEED_INIT == 8'h00) begin : g_bad_seed
        $error("lfsr_arb: SEED_INIT must be non-zero");
    end

    // Taps x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        lfsr_step = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
    function automatic logic [7:0] seed_fix(input logic [7:0] v);
        if (v == 8'h00) begin
            seed_fix = 8'h01;
        end else begin
            seed_fix = v;
        end
    endfunction

    logic [7:0]      lfsr_r;
    logic [PW-1:0]   ptr_r;
    logic [7:0]      step_cnt_r;
    logic [NREQ-1:0] gnt_r;
    logic            rnd_valid_r;
    logic [7:0]      rnd_data_r;
    logic            period_wrap_r;

    logic            any_s;
    logic [PW-1:0]   sel_s;
    logic            step_s;
    logic [7:0]      lfsr_s;
    logic [PW-1:0]   ptr_s;
    logic [7:0]      step_cnt_s;
    logic [NREQ-1:0] gnt_s;
    logic            rnd_valid_s;
    logic [7:0]      rnd_data_s;
    logic            period_wrap_s;

    // Round-robin pick: scan offsets high to low so the lowest offset from ptr wins.
    always_comb begin
        logic [IW-1:0] idx_v;
        any_s = 1'b0;
        sel_s = '0;
        idx_v = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx_v = {1'b0, ptr_r} + IW'(i);
            if (idx_v >= NREQ_W) begin
                idx_v = idx_v - NREQ_W;
            end else begin
                idx_v = idx_v;
            end
            if (req[idx_v[PW-1:0]]) begin
                any_s = 1'b1;
                sel_s = idx_v[PW-1:0];
            end else begin
                any_s = any_s;
                sel_s = sel_s;
            end
        end
    end

`ifdef LFSR_ARB_FREERUN_EN
    assign step_s = ~seed_we;
`else
    assign step_s = any_s & ~seed_we;
`endif

    // Next-state: seed load beats arbitration; LFSR and period counter advance on each step.
    always_comb begin
        lfsr_s        = lfsr_r;
        ptr_s         = ptr_r;
        step_cnt_s    = step_cnt_r;
        gnt_s         = '0;
        rnd_valid_s   = 1'b0;
        rnd_data_s    = rnd_data_r;
        period_wrap_s = 1'b0;
        if (seed_we) begin
            lfsr_s     = seed_fix(seed);
            step_cnt_s = 8'd0;
        end else begin
            if (any_s) begin
                gnt_s       = GNT_ONE << sel_s;
                rnd_valid_s = 1'b1;
                rnd_data_s  = lfsr_r;
                if (sel_s == LAST_W) begin
                    ptr_s = '0;
                end else begin
                    ptr_s = sel_s + PW'(1);
                end
            end else begin
                ptr_s = ptr_r;
            end
            if (step_s) begin
                lfsr_s = lfsr_step(lfsr_r);
                if (step_cnt_r == CNT_LAST) begin
                    step_cnt_s    = 8'd0;
                    period_wrap_s = 1'b1;
                end else begin
                    step_cnt_s = step_cnt_r + 8'd1;
                end
            end else begin
                lfsr_s = lfsr_r;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r        <= SEED_INIT;
            ptr_r         <= '0;
            step_cnt_r    <= 8'd0;
            gnt_r         <= '0;
            rnd_valid_r   <= 1'b0;
            rnd_data_r    <= 8'h00;
            period_wrap_r <= 1'b0;
        end else begin
            lfsr_r        <= lfsr_s;
            ptr_r         <= ptr_s;
            step_cnt_r    <= step_cnt_s;
            gnt_r         <= gnt_s;
            rnd_valid_r   <= rnd_valid_s;
            rnd_data_r    <= rnd_data_s;
            period_wrap_r <= period_wrap_s;
        end
    end

    assign gnt         = gnt_r;
    assign rnd_valid   = rnd_valid_r;
    assign rnd_data    = rnd_data_r;
    assign period_wrap = period_wrap_r;

endmodule

// File: tb/tb_lfsr_arb.sv
// tb_lfsr_arb: directed and randomized checks of lfsr_arb against an orbit-position reference model.
module tb_lfsr_arb;

    localparam int         NREQ      = 4;
    localparam logic [7:0] SEED_INIT = 8'h01;
`ifdef LFSR_ARB_FREERUN_EN
    localparam bit FREERUN = 1'b1;
`else
    localparam bit FREERUN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic            seed_we = 1'b0;
    logic [7:0]      seed = 8'h00;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [7:0]      rnd_data;
    logic            period_wrap;

    int total = 0;
    int bad   = 0;

    lfsr_arb #(.NREQ(NREQ), .SEED_INIT(SEED_INIT)) dut (
        .clk(clk), .rst(rst), .req(req), .seed_we(seed_we), .seed(seed),
        .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data), .period_wrap(period_wrap)
    );

    always #5 clk = ~clk;

    // The maximal LFSR visits all 255 non-zero values; the model tracks a position in that cycle.
    logic [7:0] orbit [255];
    int         pos_of [256];

    function automatic logic [7:0] poly_next(input logic [7:0] v);
        poly_next = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit              m_live = 1'b0;
    int              m_pos, m_ptr, m_steps, m_sel, m_b;
    bit              m_found;
    logic [NREQ-1:0] exp_gnt;
    logic            exp_valid, exp_wrap;
    logic [7:0]      exp_data;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pos = pos_of[SEED_INIT]; m_ptr = 0; m_steps = 0;
                exp_gnt = '0; exp_valid = 1'b0; exp_data = 8'h00; exp_wrap = 1'b0;
                m_live = 1'b1;
            end else if (m_live && seed_we) begin
                m_pos = (seed == 8'h00) ? pos_of[1] : pos_of[seed];
                m_steps = 0;
                exp_gnt = '0; exp_valid = 1'b0; exp_wrap = 1'b0;
            end else if (m_live) begin
                m_found = 1'b0; m_sel = 0;
                for (int k = 0; k < NREQ; k++) begin
                    m_b = (m_ptr + k) % NREQ;
                    if (!m_found && req[m_b]) begin
                        m_found = 1'b1; m_sel = m_b;
                    end
                end
                exp_wrap = 1'b0;
                if (m_found) begin
                    exp_gnt = NREQ'(1) << m_sel;
                    exp_valid = 1'b1;
                    exp_data = orbit[m_pos];
                    m_ptr = (m_sel + 1) % NREQ;
                end else begin
                    exp_gnt = '0;
                    exp_valid = 1'b0;
                end
                if (m_found || FREERUN) begin
                    m_pos = (m_pos + 1) % 255;
                    m_steps++;
                    exp_wrap = (m_steps % 255 == 0);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("gnt", int'(gnt), int'(exp_gnt));
                chk("rnd_valid", int'(rnd_valid), int'(exp_valid));
                chk("rnd_data", int'(rnd_data), int'(exp_data));
                chk("period_wrap", int'(period_wrap), int'(exp_wrap));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; req = '0; seed_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0]      t1_data [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    logic [NREQ-1:0] t2_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int wraps, wrap_at, missing;
    logic [7:0] v;

    initial begin
        for (int i = 0; i < 256; i++) pos_of[i] = -1;
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            orbit[i] = v;
            if (pos_of[v] == -1) pos_of[v] = i;
            v = poly_next(v);
        end
        missing = 0;
        for (int i = 1; i < 256; i++) if (pos_of[i] == -1) missing++;
        chk("orbit_distinct", missing, 0);
        chk("orbit_closes", int'(v), 8'h01);
        chk("orbit_4", int'(orbit[4]), 8'h11);
        chk("orbit_5", int'(orbit[5]), 8'h23);

        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_valid", int'(rnd_valid), 0);
        chk("rst_data", int'(rnd_data), 0);
        chk("rst_wrap", int'(period_wrap), 0);

        // Single requester held: consecutive LFSR values
        do_reset();
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t1_gnt", int'(gnt), 1);
            chk("t1_valid", int'(rnd_valid), 1);
            chk("t1_data", int'(rnd_data), int'(t1_data[k]));
        end

        // All requesting: rotation and pointer wrap
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_gnt", int'(gnt), int'(t2_gnt[k]));
            chk("t2_data", int'(rnd_data), int'(t1_data[k]));
        end

        // Zero seed is replaced by 01; seed load blocks the grant
        req = 4'b0100; seed_we = 1'b1; seed = 8'h00;
        @(negedge clk);
        chk("t3_gnt_blocked", int'(gnt), 0);
        chk("t3_valid_blocked", int'(rnd_valid), 0);
        seed_we = 1'b0;
        @(negedge clk);
        chk("t3_gnt", int'(gnt), 4);
        chk("t3_data", int'(rnd_data), 8'h01);

        // Full period after reseed
        req = 4'b1111; seed_we = 1'b1; seed = 8'hA5;
        @(negedge clk);
        seed_we = 1'b0;
        wraps = 0; wrap_at = 0;
        for (int g = 1; g <= 255; g++) begin
            @(negedge clk);
            if (g == 1) chk("t4_first", int'(rnd_data), 8'hA5);
            if (period_wrap) begin
                wraps++; wrap_at = g;
            end
        end
        chk("t4_wraps", wraps, 1);
        chk("t4_wrap_at", wrap_at, 255);
        @(negedge clk);
        chk("t4_repeat", int'(rnd_data), 8'hA5);

        // Reset while a request is pending
        rst = 1'b1; req = 4'b0010;
        @(negedge clk);
        chk("t5_gnt", int'(gnt), 0);
        chk("t5_data", int'(rnd_data), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_gnt_after", int'(gnt), 2);
        chk("t5_data_after", int'(rnd_data), 8'h01);

        // Idle cycles after reset: LFSR advances only in free-run builds
        do_reset();
        repeat (3) @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        chk("t6_data", int'(rnd_data), FREERUN ? 8'h08 : 8'h01);

        // Randomized traffic with occasional reseed and reset
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if (req[b] && gnt[b]) req[b] = ($urandom_range(1, 0) == 1);
                else if (!req[b]) req[b] = ($urandom_range(9, 0) < 4);
            end
            rst     = ($urandom_range(299, 0) == 0);
            seed_we = ($urandom_range(39, 0) == 0);
            seed    = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
